mem_stage_ctrl: RTL and testbench

Memory-stage controller for the pipelined datapath. It sits directly downstream of the EX/MEM pipeline register and consumes its memory-request and writeback fields. It issues each load/store to the data cache, stalls the pipeline until the cache reports `dhit`, and selects the writeback data. It owns the MEM/WB pipeline register and the sticky halt that ends simulation.

---
 rtl/mem_stage_ctrl_if.sv | 59 +++++
 rtl/mem_stage_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl_if
// Description : Bundle of the memory-stage controller's EX/MEM inputs, data
//               cache handshake and MEM/WB outputs.
//               master : upstream pipeline + cache side (drives EX/MEM fields,
//                        dhit, dmemload; observes everything the stage drives)
//               slave  : mem_stage_ctrl itself
//               Signal groups:
//                 EX/MEM in : dmemREN/WEN/addr/store_EX_MEM, result_EX_MEM,
//                             WEN_EX_MEM, wsel_EX_MEM, mem_to_reg_EX_MEM,
//                             halt_EX_MEM
//                 cache     : dhit, dmemload (in); dmemREN, dmemWEN, dmemaddr,
//                             dmemstore (out)
//                 pipeline  : stall_MEM, wdat/wsel/WEN/halt_MEM_WB, stall_cnt
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             dmemREN_EX_MEM;
  logic             dmemWEN_EX_MEM;
  logic [31:0]      dmemaddr_EX_MEM;
  logic [31:0]      dmemstore_EX_MEM;
  logic [31:0]      result_EX_MEM;
  logic             WEN_EX_MEM;
  logic [4:0]       wsel_EX_MEM;
  logic             mem_to_reg_EX_MEM;
  logic             halt_EX_MEM;
  logic             dhit;
  logic [31:0]      dmemload;
  logic             dmemREN;
  logic             dmemWEN;
  logic [31:0]      dmemaddr;
  logic [31:0]      dmemstore;
  logic             stall_MEM;
  logic [31:0]      wdat_MEM_WB;
  logic [4:0]       wsel_MEM_WB;
  logic             WEN_MEM_WB;
  logic             halt_MEM_WB;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM,
           result_EX_MEM, WEN_EX_MEM, wsel_EX_MEM, mem_to_reg_EX_MEM,
           halt_EX_MEM, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, stall_MEM, wdat_MEM_WB,
           wsel_MEM_WB, WEN_MEM_WB, halt_MEM_WB, stall_cnt
  );

  modport slave (
    input  dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM,
           result_EX_MEM, WEN_EX_MEM, wsel_EX_MEM, mem_to_reg_EX_MEM,
           halt_EX_MEM, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, stall_MEM, wdat_MEM_WB,
           wsel_MEM_WB, WEN_MEM_WB, halt_MEM_WB, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : Memory-stage controller. Issues EX/MEM loads/stores to the
//               data cache, stalls the pipeline until dhit, owns the MEM/WB
//               register, the sticky halt and a saturating stall counter.
// Ports       : CLK   - system clock, rising edge
//               nRST  - asynchronous active-low reset
//               bus   - mem_stage_ctrl_if.slave (EX/MEM fields, cache
//                       handshake, MEM/WB outputs, stall_MEM, stall_cnt)
// Parameters  : CNT_W - width of the saturating stall-cycle counter
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  mem_stage_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;

  // Copy of the EX/MEM fields, refreshed every IDLE cycle and frozen in WAIT
  logic             r_hold_wr;
  logic             r_hold_rd;
  logic [31:0]      r_hold_addr;
  logic [31:0]      r_hold_store;
  logic [31:0]      r_hold_result;
  logic             r_hold_wen;
  logic [4:0]       r_hold_wsel;
  logic             r_hold_m2r;

  logic [31:0]      r_wdat;
  logic [4:0]       r_wsel;
  logic             r_wen;
  logic             r_halt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_wr;
  logic             w_rd;
  logic             w_req;
  logic             w_ren_out;
  logic             w_wen_out;
  logic [31:0]      w_addr_out;
  logic [31:0]      w_store_out;
  logic             w_stall;

  // A simultaneous read and write request is treated as a write only
  assign w_wr  = bus.dmemWEN_EX_MEM;
  assign w_rd  = bus.dmemREN_EX_MEM & ~bus.dmemWEN_EX_MEM;
  assign w_req = w_wr | w_rd;

  // Cache drive and stall. In WAIT only the hold registers reach the cache so
  // the request stays stable while the upstream fields move.
  always_comb begin
    w_ren_out   = 1'b0;
    w_wen_out   = 1'b0;
    w_addr_out  = 32'd0;
    w_store_out = 32'd0;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_ren_out   = w_rd;
        w_wen_out   = w_wr;
        w_addr_out  = bus.dmemaddr_EX_MEM;
        w_store_out = bus.dmemstore_EX_MEM;
        w_stall     = w_req & ~bus.dhit;
      end
      ST_WAIT: begin
        w_ren_out   = r_hold_rd;
        w_wen_out   = r_hold_wr;
        w_addr_out  = r_hold_addr;
        w_store_out = r_hold_store;
        w_stall     = ~bus.dhit;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= ST_IDLE;
      r_hold_wr     <= 1'b0;
      r_hold_rd     <= 1'b0;
      r_hold_addr   <= 32'd0;
      r_hold_store  <= 32'd0;
      r_hold_result <= 32'd0;
      r_hold_wen    <= 1'b0;
      r_hold_wsel   <= 5'd0;
      r_hold_m2r    <= 1'b0;
      r_wdat        <= 32'd0;
      r_wsel        <= 5'd0;
      r_wen         <= 1'b0;
      r_halt        <= 1'b0;
      r_stall_cnt   <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != C_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + C_CNT_ONE;
      end

      case (r_state)
        ST_IDLE: begin
          r_hold_wr     <= w_wr;
          r_hold_rd     <= w_rd;
          r_hold_addr   <= bus.dmemaddr_EX_MEM;
          r_hold_store  <= bus.dmemstore_EX_MEM;
          r_hold_result <= bus.result_EX_MEM;
          r_hold_wen    <= bus.WEN_EX_MEM;
          r_hold_wsel   <= bus.wsel_EX_MEM;
          r_hold_m2r    <= bus.mem_to_reg_EX_MEM;
          if (w_req && !bus.dhit) begin
            // Miss: bubble into MEM/WB and wait for the cache
            r_wdat  <= 32'd0;
            r_wsel  <= 5'd0;
            r_wen   <= 1'b0;
            r_state <= ST_WAIT;
          end else begin
            // Hit in the issue cycle, or a non-memory instruction
            r_wdat <= bus.mem_to_reg_EX_MEM ? bus.dmemload : bus.result_EX_MEM;
            r_wsel <= bus.wsel_EX_MEM;
            r_wen  <= bus.WEN_EX_MEM;
            if (!w_req && bus.halt_EX_MEM) begin
              r_halt  <= 1'b1;
              r_state <= ST_HALTED;
            end
          end
        end

        ST_WAIT: begin
          if (bus.dhit) begin
            r_wdat  <= r_hold_m2r ? bus.dmemload : r_hold_result;
            r_wsel  <= r_hold_wsel;
            r_wen   <= r_hold_wen;
            r_state <= ST_IDLE;
          end else begin
            r_wdat <= 32'd0;
            r_wsel <= 5'd0;
            r_wen  <= 1'b0;
          end
        end

        ST_HALTED: begin
          r_wdat <= 32'd0;
          r_wsel <= 5'd0;
          r_wen  <= 1'b0;
          r_halt <= 1'b1;
        end

        default: begin
          // Unused encoding: recover to IDLE with a bubble
          r_wdat  <= 32'd0;
          r_wsel  <= 5'd0;
          r_wen   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.dmemREN     = w_ren_out;
  assign bus.dmemWEN     = w_wen_out;
  assign bus.dmemaddr    = w_addr_out;
  assign bus.dmemstore   = w_store_out;
  assign bus.stall_MEM   = w_stall;
  assign bus.wdat_MEM_WB = r_wdat;
  assign bus.wsel_MEM_WB = r_wsel;
  assign bus.WEN_MEM_WB  = r_wen;
  assign bus.halt_MEM_WB = r_halt;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_ctrl
// Description : Self-checking bench for mem_stage_ctrl. Directed scenarios
//               followed by randomized traffic, all compared against a
//               transaction-level reference model (outstanding-request queue).
//               A narrow counter is used so saturation is reached.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_ctrl;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic CLK = 1'b0;
  logic nRST;

  mem_stage_ctrl_if #(.CNT_W(CNT_W)) bus ();

  mem_stage_ctrl #(.CNT_W(CNT_W)) u_dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          wr;
    bit          rd;
    logic [31:0] addr;
    logic [31:0] store;
    logic [31:0] result;
    bit          wen;
    logic [4:0]  wsel;
    bit          m2r;
    bit          halt;
  } req_t;

  req_t        pend[$];   // request issued but not yet answered by dhit
  bit          m_halted;
  logic [31:0] m_wdat;
  logic [4:0]  m_wsel;
  bit          m_wen;
  int          m_cnt;

  task automatic model_reset();
    pend.delete();
    m_halted = 0;
    m_wdat   = 0;
    m_wsel   = 0;
    m_wen    = 0;
    m_cnt    = 0;
  endtask

  task automatic bubble();
    m_wdat = 0;
    m_wsel = 0;
    m_wen  = 0;
  endtask

  task automatic retire(input req_t r, input logic [31:0] load);
    m_wdat = r.m2r ? load : r.result;
    m_wsel = r.wsel;
    m_wen  = r.wen;
  endtask

  task automatic drive(input bit ren, input bit wen, input logic [31:0] addr,
                       input logic [31:0] store, input logic [31:0] result,
                       input bit we, input logic [4:0] ws, input bit m2r,
                       input bit halt, input bit dh, input logic [31:0] load);
    bus.dmemREN_EX_MEM    = ren;
    bus.dmemWEN_EX_MEM    = wen;
    bus.dmemaddr_EX_MEM   = addr;
    bus.dmemstore_EX_MEM  = store;
    bus.result_EX_MEM     = result;
    bus.WEN_EX_MEM        = we;
    bus.wsel_EX_MEM       = ws;
    bus.mem_to_reg_EX_MEM = m2r;
    bus.halt_EX_MEM       = halt;
    bus.dhit              = dh;
    bus.dmemload          = load;
  endtask

  task automatic check_wb(input string tag);
    check({tag, "_wdat"}, bus.wdat_MEM_WB, m_wdat);
    check({tag, "_wsel"}, bus.wsel_MEM_WB, m_wsel);
    check({tag, "_wen"},  bus.WEN_MEM_WB,  m_wen);
    check({tag, "_halt"}, bus.halt_MEM_WB, m_halted);
    check({tag, "_cnt"},  bus.stall_cnt,   m_cnt);
  endtask

  // One clock cycle; called just after a falling edge with inputs driven.
  task automatic step();
    req_t        cur;
    req_t        drv;
    bit          e_stall;
    bit          dh;
    logic [31:0] load;
    cur.wr     = bus.dmemWEN_EX_MEM;
    cur.rd     = bus.dmemREN_EX_MEM && !bus.dmemWEN_EX_MEM;
    cur.addr   = bus.dmemaddr_EX_MEM;
    cur.store  = bus.dmemstore_EX_MEM;
    cur.result = bus.result_EX_MEM;
    cur.wen    = bus.WEN_EX_MEM;
    cur.wsel   = bus.wsel_EX_MEM;
    cur.m2r    = bus.mem_to_reg_EX_MEM;
    cur.halt   = bus.halt_EX_MEM;
    dh         = bus.dhit;
    load       = bus.dmemload;
    #2;
    drv = '{default: 0};
    e_stall = 0;
    if (m_halted) begin
      drv = '{default: 0};
    end else if (pend.size() != 0) begin
      drv     = pend[0];
      e_stall = !dh;
    end else begin
      drv     = cur;
      e_stall = (cur.wr || cur.rd) && !dh;
    end
    check("ren",   bus.dmemREN,   drv.rd);
    check("wen",   bus.dmemWEN,   drv.wr);
    check("addr",  bus.dmemaddr,  drv.addr);
    check("store", bus.dmemstore, drv.store);
    check("stall", bus.stall_MEM, e_stall);

    if (m_halted) begin
      bubble();
    end else if (pend.size() != 0) begin
      if (dh) retire(pend.pop_front(), load);
      else    bubble();
    end else if (cur.wr || cur.rd) begin
      if (dh) retire(cur, load);
      else begin
        pend.push_back(cur);
        bubble();
      end
    end else begin
      retire(cur, load);
      if (cur.halt) m_halted = 1;
    end
    if (e_stall && m_cnt < CNT_MAX) m_cnt++;

    @(posedge CLK);
    #1;
    check_wb("wb");
    @(negedge CLK);
  endtask

  // Asynchronous reset asserted in the middle of the low clock phase.
  task automatic do_reset();
    #2 nRST = 1'b0;
    #1;
    model_reset();
    check_wb("rst");
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic drive_random(input bit allow_halt);
    bit ren, wen, m2r, halt;
    ren  = ($urandom % 3) == 0;
    wen  = ($urandom % 4) == 0;
    m2r  = ren && !wen && ($urandom % 2);
    halt = allow_halt && !ren && !wen && (($urandom % 150) == 0);
    drive(ren, wen, $urandom, $urandom, halt ? 32'd0 : $urandom,
          halt ? 1'b0 : 1'($urandom % 2), halt ? 5'd0 : 5'($urandom),
          m2r, halt, ($urandom % 5) < 2, $urandom);
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge CLK);
    check_wb("init");
    nRST = 1'b1;

    // Load hit in the issue cycle
    drive(1, 0, 32'h100, 0, 32'h55, 1, 5, 1, 0, 1, 32'hDEADBEEF);
    step();
    check("lh_wen",  bus.WEN_MEM_WB,  1'b1);
    check("lh_wsel", bus.wsel_MEM_WB, 5'd5);
    check("lh_wdat", bus.wdat_MEM_WB, 32'hDEADBEEF);
    check("lh_cnt",  bus.stall_cnt,   0);

    // Store miss answered three cycles later, inputs moving meanwhile
    drive(0, 1, 32'h200, 32'h12345678, 32'h9, 0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, $urandom, $urandom, $urandom, 1, 5'($urandom), 1, 0, 0, $urandom);
      step();
    end
    drive(1, 1, 32'h300, 32'h1, 32'h2, 1, 7, 0, 0, 1, 32'h44);
    #1;
    check("sm_addr_last",  bus.dmemaddr,  32'h200);
    check("sm_store_last", bus.dmemstore, 32'h12345678);
    step();
    check("sm_cnt", bus.stall_cnt, 3);

    // Both requests together: only the write reaches the cache
    drive(1, 1, 32'h400, 32'hA5A5, 32'h0, 0, 0, 0, 0, 1, 32'h77);
    #1;
    check("both_ren", bus.dmemREN, 1'b0);
    check("both_wen", bus.dmemWEN, 1'b1);
    step();

    // ALU op followed directly by a load hit
    drive(0, 0, 0, 0, 32'd7, 1, 3, 0, 0, 0, 0);
    step();
    check("b2b_wdat0", bus.wdat_MEM_WB, 32'd7);
    check("b2b_wen0",  bus.WEN_MEM_WB,  1'b1);
    drive(1, 0, 32'h10, 0, 0, 1, 9, 1, 0, 1, 32'hCAFEF00D);
    step();
    check("b2b_wdat1", bus.wdat_MEM_WB, 32'hCAFEF00D);
    check("b2b_wen1",  bus.WEN_MEM_WB,  1'b1);

    // Halt, then a load and a dhit that must both be ignored
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    step();
    check("halt_set", bus.halt_MEM_WB, 1'b1);
    drive(1, 0, 32'h20, 0, 32'h5, 1, 4, 1, 0, 1, 32'h99);
    #1;
    check("halt_ren", bus.dmemREN, 1'b0);
    step();
    check("halt_keep", bus.halt_MEM_WB, 1'b1);
    check("halt_bub",  bus.WEN_MEM_WB,  1'b0);
    do_reset();

    // Reset while a load is waiting for the cache
    drive(1, 0, 32'h40, 0, 0, 1, 2, 1, 0, 0, 0);
    step();
    drive(0, 0, 32'h80, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("wait_ren", bus.dmemREN, 1'b1);
    do_reset();
    drive(1, 0, 32'h84, 0, 0, 1, 1, 1, 0, 0, 0);
    #1;
    check("post_rst_ren",  bus.dmemREN,  1'b1);
    check("post_rst_addr", bus.dmemaddr, 32'h84);
    step();

    // Randomized traffic with occasional halts and asynchronous resets
    for (int n = 0; n < 3000; n++) begin
      if ((m_halted && ($urandom % 10) == 0) || ($urandom % 300) == 0) begin
        do_reset();
      end else begin
        drive_random(1'b1);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
